// File: rtl/display_pkg.sv
// Shared types and source-select codes for the VGA display path.
package display_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FADE_OUT = 2'd1,
    SWAP     = 2'd2,
    FADE_IN  = 2'd3
  } seq_state_t;

  localparam logic [2:0] SRC_TESTBARS = 3'd0;
  localparam logic [2:0] SRC_GOL      = 3'd1;
  localparam logic [2:0] SRC_SNAKE    = 3'd2;
  localparam logic [2:0] SRC_TETRIS   = 3'd3;
  localparam logic [2:0] SRC_GREY60   = 3'd4;
  localparam logic [2:0] SRC_GREY90   = 3'd5;
  localparam logic [2:0] SRC_GREYC0   = 3'd6;
  localparam logic [2:0] SRC_GREYFF   = 3'd7;

endpackage

// File: rtl/display_source_sequencer_pixel_fader.sv
// Per-channel brightness scaling of a 24-bit RGB pixel, registered output.
module pixel_fader #(
  parameter  int unsigned FADE_FRAMES = 8,
  localparam int unsigned LW          = $clog2(FADE_FRAMES) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [LW-1:0] level,
  input  logic [23:0]   pixel_in,
  output logic [23:0]   pixel_out
);

  localparam int unsigned SH = $clog2(FADE_FRAMES);
  localparam int unsigned PW = 8 + SH + 1;

  logic [23:0] scaled;

  // (ch * level) >> SH; full level is exactly FADE_FRAMES so ch passes unchanged
  function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [LW-1:0] lvl);
    logic [PW-1:0] prod;
    prod = PW'(ch) * PW'(lvl);
    return 8'(prod >> SH);
  endfunction

  // Scale all three channels by the current level
  always_comb begin
    scaled = '0;
    scaled = {scale_ch(pixel_in[23:16], level),
              scale_ch(pixel_in[15:8],  level),
              scale_ch(pixel_in[7:0],   level)};
  end

  // One-cycle output register toward the VGA block
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pixel_out <= '0;
    else     pixel_out <= scaled;
  end

endmodule

// File: rtl/display_source_sequencer.sv
// Debounced, frame-aligned source selection with optional fade ramp.
module display_source_sequencer
  import display_pkg::*;
#(
  parameter  int unsigned SEL_W         = 3,
  parameter  int unsigned COORD_W       = 11,
  parameter  int unsigned FADE_FRAMES   = 8,
  parameter  int unsigned STABLE_FRAMES = 4,
  parameter  int unsigned RESET_SEL     = 0,
  localparam int unsigned LW            = $clog2(FADE_FRAMES) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SEL_W-1:0]   sel_req,
  input  logic               fade_en,
  input  logic [COORD_W-1:0] row,
  input  logic [23:0]        pixel_in,
  output logic [SEL_W-1:0]   active_sel,
  output logic [LW-1:0]      fade_level,
  output logic [23:0]        pixel_out,
  output logic               busy,
  output logic               switch_pulse
);

  localparam int unsigned       CW      = $clog2(STABLE_FRAMES + 1);
  localparam logic [CW-1:0]     STAB    = CW'(STABLE_FRAMES);
  localparam logic [LW-1:0]     FULL    = LW'(FADE_FRAMES);
  localparam logic [SEL_W-1:0]  RST_SEL = SEL_W'(RESET_SEL);

  logic [SEL_W-1:0]   sync1, req_s, req_d, target;
  logic [COORD_W-1:0] prev_row;
  logic [CW-1:0]      stab_cnt;
  logic               frame_tick;

  seq_state_t         state, state_n;
  logic [SEL_W-1:0]   sel_n;
  logic [LW-1:0]      level_n;
  logic               pulse_n;

  assign frame_tick = (row == '0) && (prev_row != '0);
  assign busy       = (state != RUN);

  // Synchroniser, frame-edge detect and stability filter feeding target
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= RST_SEL;
      req_s    <= RST_SEL;
      req_d    <= RST_SEL;
      prev_row <= '0;
      stab_cnt <= '0;
      target   <= RST_SEL;
    end else begin
      sync1    <= sel_req;
      req_s    <= sync1;
      req_d    <= req_s;
      prev_row <= row;
      if (req_s != req_d)
        stab_cnt <= '0;
      else if (frame_tick && stab_cnt != STAB)
        stab_cnt <= stab_cnt + 1'b1;
      // the req_s==req_d guard stops a fresh change slipping through on the
      // same cycle a saturated count is being cleared
      if (stab_cnt == STAB && req_s == req_d)
        target <= req_s;
    end
  end

  // Sequencer next state: only frame ticks move it
  always_comb begin
    state_n = state;
    sel_n   = active_sel;
    level_n = fade_level;
    pulse_n = 1'b0;
    if (frame_tick) begin
      if (state != RUN && !fade_en) begin
        state_n = RUN;
        level_n = FULL;
        sel_n   = target;
        pulse_n = (target != active_sel);
      end else begin
        case (state)
          RUN: begin
            if (target != active_sel) begin
              if (!fade_en) begin
                sel_n   = target;
                pulse_n = 1'b1;
              end else begin
                state_n = FADE_OUT;
                level_n = fade_level - 1'b1;
              end
            end
          end
          FADE_OUT: begin
            if (target == active_sel) begin
              state_n = FADE_IN;
            end else begin
              level_n = fade_level - 1'b1;
              if (fade_level == LW'(1)) state_n = SWAP;
            end
          end
          SWAP: begin
            sel_n   = target;
            pulse_n = (target != active_sel);
            state_n = FADE_IN;
          end
          FADE_IN: begin
            if (target != active_sel) begin
              // a level already at 0 goes straight to the swap frame
              if (fade_level <= LW'(1)) begin
                level_n = '0;
                state_n = SWAP;
              end else begin
                level_n = fade_level - 1'b1;
                state_n = FADE_OUT;
              end
            end else begin
              level_n = fade_level + 1'b1;
              if (fade_level == FULL - 1'b1) state_n = RUN;
            end
          end
        endcase
      end
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      active_sel   <= RST_SEL;
      fade_level   <= FULL;
      switch_pulse <= 1'b0;
    end else begin
      state        <= state_n;
      active_sel   <= sel_n;
      fade_level   <= level_n;
      switch_pulse <= pulse_n;
    end
  end

  pixel_fader #(
    .FADE_FRAMES(FADE_FRAMES)
  ) u_fader (
    .clk      (clk),
    .rst      (rst),
    .level    (fade_level),
    .pixel_in (pixel_in),
    .pixel_out(pixel_out)
  );

endmodule

// File: tb/tb_display_source_sequencer.sv
// Scoreboard bench for display_source_sequencer (8-cycle frames, 4 rows of 2 clks).
module tb_display_source_sequencer;

  localparam int unsigned LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    sel_req;
  logic          fade_en;
  logic [10:0]   row;
  logic [23:0]   pixel_in;
  logic [2:0]    active_sel;
  logic [LW-1:0] fade_level;
  logic [23:0]   pixel_out;
  logic          busy;
  logic          switch_pulse;

  display_source_sequencer #(
    .SEL_W(3), .COORD_W(11), .FADE_FRAMES(8), .STABLE_FRAMES(4), .RESET_SEL(0)
  ) dut (
    .clk(clk), .rst(rst), .sel_req(sel_req), .fade_en(fade_en), .row(row),
    .pixel_in(pixel_in), .active_sel(active_sel), .fade_level(fade_level),
    .pixel_out(pixel_out), .busy(busy), .switch_pulse(switch_pulse)
  );

  always #10 clk = ~clk;

  typedef struct {
    int unsigned level;
    int unsigned sel;
    int unsigned busy;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  bit          have_cur = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;
  int unsigned age = 99;
  int unsigned tick_cnt = 0;
  int unsigned pulse_cnt = 0;
  int unsigned min_level = 99;
  logic [10:0] last_row;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] fade_px(input logic [23:0] p, input int unsigned lvl);
    int unsigned r, g, b;
    r = (32'(p[23:16]) * lvl) / 8;
    g = (32'(p[15:8])  * lvl) / 8;
    b = (32'(p[7:0])   * lvl) / 8;
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  // One clock: observe at negedge, compare against scoreboard, drive next row.
  // age==1 is the first negedge after a frame-tick clock edge.
  task automatic step();
    @(negedge clk);
    if (age < 99) age++;
    if (age == 1) begin
      tick_cnt++;
      if (exp_q.size() > 0) begin
        cur      = exp_q.pop_front();
        have_cur = 1'b1;
        check("tick_level", 32'(fade_level), cur.level);
        check("tick_sel",   32'(active_sel), cur.sel);
        check("tick_busy",  32'(busy),       cur.busy);
      end else begin
        have_cur = 1'b0;
      end
      if (fade_level < min_level) min_level = 32'(fade_level);
    end
    if (age == 3 && have_cur)
      check("pixel", 32'(pixel_out), 32'(fade_px(pixel_in, cur.level)));
    if (switch_pulse) begin
      pulse_cnt++;
      check("pulse_at_tick", age, 32'd1);
    end
    row = 11'((cyc / 2) % 4);
    cyc++;
    if (row == 0 && last_row != 0) age = 0;
    last_row = row;
  endtask

  task automatic align();
    for (int i = 0; i < 16; i++) begin
      step();
      if (age == 1) return;
    end
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 96; i++) begin
      step();
      if (busy) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    bit          ok;
    int unsigned t0, p0;

    rst = 1'b1; sel_req = 3'd3; fade_en = 1'b0; row = '0; last_row = '0;
    pixel_in = 24'hFFFFFF;
    repeat (3) @(negedge clk);
    check("rst_sel",   32'(active_sel),   32'd0);
    check("rst_level", 32'(fade_level),   32'd8);
    check("rst_pixel", 32'(pixel_out),    32'd0);
    check("rst_busy",  32'(busy),         32'd0);
    check("rst_pulse", 32'(switch_pulse), 32'd0);
    sel_req = 3'd0;
    rst     = 1'b0;

    // idle: request equals reset selection for 10 frames
    repeat (80) step();
    check("idle_pulses", pulse_cnt, 32'd0);
    check("idle_sel", 32'(active_sel), 32'd0);

    // glitch shorter than the stability window
    align();
    sel_req = 3'd2;
    repeat (16) step();
    sel_req = 3'd0;
    repeat (64) step();
    check("glitch_pulses", pulse_cnt, 32'd0);
    check("glitch_sel", 32'(active_sel), 32'd0);
    check("glitch_busy", 32'(busy), 32'd0);

    // hard cut 0 -> 3: accepted after STABLE_FRAMES ticks, acted on at a tick
    align();
    sel_req = 3'd3;
    t0 = tick_cnt; p0 = pulse_cnt; ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      step();
      if (pulse_cnt != p0) ok = 1'b1;
    end
    check("cut_seen", 32'(ok), 32'd1);
    check("cut_latency_ok", 32'((tick_cnt - t0) >= 4 && (tick_cnt - t0) <= 5), 32'd1);
    check("cut_sel", 32'(active_sel), 32'd3);
    check("cut_busy", 32'(busy), 32'd0);
    repeat (16) step();
    check("cut_one_pulse", pulse_cnt, p0 + 1);

    // full fade 3 -> 1 with a fixed pixel
    fade_en = 1'b1; pixel_in = 24'hFF8040;
    align();
    sel_req = 3'd1; p0 = pulse_cnt;
    wait_busy(ok);
    check("fade_start", 32'(ok), 32'd1);
    check("fade_first_level", 32'(fade_level), 32'd7);
    cur = '{level: 7, sel: 3, busy: 1}; have_cur = 1'b1;
    for (int l = 6; l >= 0; l--) exp_q.push_back('{level: l, sel: 3, busy: 1});
    exp_q.push_back('{level: 0, sel: 1, busy: 1});
    for (int l = 1; l <= 7; l++) exp_q.push_back('{level: l, sel: 1, busy: 1});
    exp_q.push_back('{level: 8, sel: 1, busy: 0});
    repeat (130) step();
    check("fade_q_drained", exp_q.size(), 32'd0);
    check("fade_pulses", pulse_cnt, p0 + 1);
    check("fade_px_full", 32'(pixel_out), 32'hFF8040);
    check("fade_l7_px", 32'(fade_px(24'hFF8040, 7)), 32'hDF7038);

    // withdrawn request during fade-out
    align();
    sel_req = 3'd2; p0 = pulse_cnt;
    wait_busy(ok);
    check("wd_start", 32'(ok), 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      step();
      if (age == 1 && fade_level == 5) ok = 1'b1;
    end
    check("wd_reach5", 32'(ok), 32'd1);
    sel_req = 3'd1; min_level = 99;
    repeat (112) step();
    check("wd_level", 32'(fade_level), 32'd8);
    check("wd_busy", 32'(busy), 32'd0);
    check("wd_sel", 32'(active_sel), 32'd1);
    check("wd_pulses", pulse_cnt, p0);
    check("wd_no_black", 32'(min_level != 0), 32'd1);

    // reset asynchronously at level 3 of a fade-in
    align();
    sel_req = 3'd3;
    wait_busy(ok);
    check("rm_start", 32'(ok), 32'd1);
    t0 = 0; ok = 1'b0;
    for (int i = 0; i < 240 && !ok; i++) begin
      step();
      if (age == 1) begin
        if (fade_level == 0) t0 = 1;
        if (t0 == 1 && fade_level == 3) ok = 1'b1;
      end
    end
    check("rm_reach3", 32'(ok), 32'd1);
    check("rm_pre_sel", 32'(active_sel), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("rm_sel",   32'(active_sel),   32'd0);
    check("rm_level", 32'(fade_level),   32'd8);
    check("rm_pixel", 32'(pixel_out),    32'd0);
    check("rm_busy",  32'(busy),         32'd0);
    check("rm_pulse", 32'(switch_pulse), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
